mmu09_intctl: RTL



---
 rtl/mmu09_pkg.sv | 18 +
 rtl/mmu09_intctl_if.sv | 14 +
 rtl/mmu09_sync_edge.sv | 29 ++
 rtl/mmu09_intctl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mmu09_pkg.sv
// Shared constants for the MMU09 interrupt responder: register map and NMI state encoding.
package mmu09_pkg;

   localparam int unsigned REG_AW    = 2;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned NMI_CNT_W = 4;

   localparam logic [REG_AW-1:0] REG_STATUS = 2'd0;
   localparam logic [REG_AW-1:0] REG_MASK   = 2'd1;
   localparam logic [REG_AW-1:0] REG_ROUTE  = 2'd2;
   localparam logic [REG_AW-1:0] REG_NMICTL = 2'd3;

   typedef enum logic {
      NMI_IDLE  = 1'b0,
      NMI_PULSE = 1'b1
   } nmi_state_e;

endpackage

// File: rtl/mmu09_intctl_if.sv
// 6809 register-bus view of the interrupt responder.
interface mmu09_intctl_if;
   import mmu09_pkg::*;

   logic              cs;
   logic              rw;
   logic [REG_AW-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;

   modport master (output cs, output rw, output addr, output din, input dout);
   modport slave  (input cs, input rw, input addr, input din, output dout);

endinterface

// File: rtl/mmu09_sync_edge.sv
// Two-flop synchronizer with a third stage for rising-edge detection.
module mmu09_sync_edge #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise_c
);

   logic [W-1:0] s1, s2, s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign q      = s2;
   assign rise_c = s2 & ~s3;

endmodule

// File: rtl/mmu09_intctl.sv
// MMU09 interrupt responder: source latching, mask/route registers, IRQ/FIRQ drive
// and an NMI pulse generator timed in E cycles.
module mmu09_intctl
   import mmu09_pkg::*;
#(
   parameter int unsigned NSRC      = 8,
   parameter logic [7:0]  EDGE_MASK = 8'h00,
   parameter int unsigned NMI_WIDTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            eclk,
   mmu09_intctl_if.slave   bus,
   input  logic [NSRC-1:0] src,
   input  logic            nmi_req,
   output logic            irq_n,
   output logic            firq_n,
   output logic            nmi_n
);

   localparam logic [DATA_W-1:0] SRC_VALID = DATA_W'((9'd1 << NSRC) - 9'd1);
   localparam logic [DATA_W-1:0] EDGE_SEL  = EDGE_MASK & SRC_VALID;

   logic [NSRC-1:0]      src_q, src_rise_c;
   logic                 unused_nmi_level, nmi_rise_c;
   logic                 eclk_d, efall_c, wr_c, nmi_trig_c, nmi_active_c;
   logic [DATA_W-1:0]    pending, mask, route, clr_c;
   nmi_state_e           nmi_state, nmi_state_nx;
   logic [NMI_CNT_W-1:0] nmi_cnt, nmi_cnt_nx;
   logic                 nmi_latched, nmi_latched_nx;

   mmu09_sync_edge #(.W(NSRC)) u_sync_src (
      .clk    (clk),
      .reset  (reset),
      .d      (src),
      .q      (src_q),
      .rise_c (src_rise_c)
   );

   mmu09_sync_edge #(.W(1)) u_sync_nmi (
      .clk    (clk),
      .reset  (reset),
      .d      (nmi_req),
      .q      (unused_nmi_level),
      .rise_c (nmi_rise_c)
   );

   always_ff @(posedge clk) begin
      if (reset) eclk_d <= 1'b0;
      else       eclk_d <= eclk;
   end

   assign efall_c    = eclk_d & ~eclk;
   assign wr_c       = efall_c & bus.cs & ~bus.rw;
   assign clr_c      = (wr_c && bus.addr == REG_STATUS) ? bus.din : '0;
   assign nmi_trig_c = nmi_rise_c | (wr_c && bus.addr == REG_NMICTL);

   // Edge bits: a fresh rising edge beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         mask    <= '0;
         route   <= '0;
      end else begin
         pending <= (DATA_W'(src_q) & ~EDGE_SEL)
                  | (EDGE_SEL & ((pending & ~clr_c) | DATA_W'(src_rise_c)));
         if (wr_c && bus.addr == REG_MASK)  mask  <= bus.din & SRC_VALID;
         if (wr_c && bus.addr == REG_ROUTE) route <= bus.din & SRC_VALID;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_n  <= 1'b1;
         firq_n <= 1'b1;
      end else begin
         irq_n  <= ~|(pending & mask & ~route);
         firq_n <= ~|(pending & mask & route);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nmi_state   <= NMI_IDLE;
         nmi_cnt     <= '0;
         nmi_latched <= 1'b0;
      end else begin
         nmi_state   <= nmi_state_nx;
         nmi_cnt     <= nmi_cnt_nx;
         nmi_latched <= nmi_latched_nx;
      end
   end

   // A latched retrigger waits in IDLE for the next E fall, giving one full E cycle high.
   always_comb begin
      nmi_state_nx   = nmi_state;
      nmi_cnt_nx     = nmi_cnt;
      nmi_latched_nx = nmi_latched;
      case (nmi_state)
         NMI_IDLE: begin
            if (nmi_latched) begin
               if (efall_c) begin
                  nmi_state_nx   = NMI_PULSE;
                  nmi_cnt_nx     = NMI_CNT_W'(NMI_WIDTH);
                  nmi_latched_nx = 1'b0;
               end
            end else if (nmi_trig_c) begin
               nmi_state_nx = NMI_PULSE;
               nmi_cnt_nx   = NMI_CNT_W'(NMI_WIDTH);
            end
         end
         NMI_PULSE: begin
            if (nmi_trig_c) nmi_latched_nx = 1'b1;
            if (efall_c) begin
               if (nmi_cnt <= NMI_CNT_W'(1)) begin
                  nmi_state_nx = NMI_IDLE;
                  nmi_cnt_nx   = '0;
               end else begin
                  nmi_cnt_nx = nmi_cnt - NMI_CNT_W'(1);
               end
            end
         end
         default: nmi_state_nx = NMI_IDLE;
      endcase
   end

   always_comb begin
      nmi_active_c = 1'b0;
      if (nmi_state == NMI_PULSE) nmi_active_c = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) nmi_n <= 1'b1;
      else       nmi_n <= ~nmi_active_c;
   end

   always_comb begin
      bus.dout = '0;
      case (bus.addr)
         REG_STATUS: bus.dout = pending;
         REG_MASK:   bus.dout = mask;
         REG_ROUTE:  bus.dout = route;
         REG_NMICTL: bus.dout = {6'b0, nmi_active_c, nmi_latched};
         default:    bus.dout = '0;
      endcase
   end

endmodule
